alu_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the hiddenCPU datapath. It fetches 8-bit instructions from program memory over a req/ack handshake and drives the ALU's `opcode`/`addrs` inputs. It qualifies the ALU's branch requests (`bcf`, `bbf`, `buc`) against its own latched carry/borrow flags, then commits either an accumulator write or a PC redirect. It sits between the program memory and the `alu` instance and owns the PC, instruction register, flags and the toggle output bit.

---
 rtl/alu_sequencer.sv | 115 +++++++++++
 tb/tb_alu_sequencer.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Fetch/execute/writeback sequencer for the hiddenCPU ALU: owns PC, IR, carry/borrow flags and the toggle bit.
// Optional single-step input enabled by defining ALU_SEQ_STEP_EN.
module alu_sequencer #(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
`ifdef ALU_SEQ_STEP_EN
  input  logic            step,
`endif
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [7:0]      imem_data,
  output logic [1:0]      alu_opcode,
  output logic [3:0]      alu_addrs,
  input  logic            alu_carry,
  input  logic            alu_borrow,
  input  logic            alu_bcf,
  input  logic            alu_bbf,
  input  logic            alu_buc,
  input  logic            alu_toggle,
  output logic            acc_we,
  output logic            out_bit,
  output logic [PC_W-1:0] pc,
  output logic [7:0]      instret,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} stateType;

  stateType   state;
  logic [5:0] irField;
  logic       carryFlag;
  logic       borrowFlag;
  logic       taken;
  logic       isBr;
  logic       startReq;
  logic       brReq;
  logic       unusedBits;

`ifdef ALU_SEQ_STEP_EN
  assign startReq = run | step;
`else
  assign startReq = run;
`endif

  // Only ir[7:2] carries meaning; the two reserved bits are never stored.
  assign unusedBits = ^imem_data[1:0];
  assign brReq      = alu_buc | alu_bcf | alu_bbf;
  assign imem_addr  = pc;
  assign alu_opcode = irField[5:4];
  assign alu_addrs  = irField[3:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      irField    <= '0;
      pc         <= '0;
      instret    <= '0;
      carryFlag  <= 1'b0;
      borrowFlag <= 1'b0;
      taken      <= 1'b0;
      isBr       <= 1'b0;
      out_bit    <= 1'b0;
      imem_req   <= 1'b0;
      acc_we     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (startReq) begin
            state    <= FETCH;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        FETCH: begin
          if (imem_ack) begin
            irField  <= imem_data[7:2];
            imem_req <= 1'b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          // Branch qualification uses the flags left by the previous instruction.
          taken <= alu_buc | (alu_bcf & carryFlag) | (alu_bbf & borrowFlag);
          isBr  <= brReq;
          if (!brReq) begin
            carryFlag  <= alu_carry;
            borrowFlag <= alu_borrow;
          end
          if (alu_toggle) out_bit <= ~out_bit;
          acc_we <= ~brReq;
          state  <= WB;
        end
        WB: begin
          acc_we  <= 1'b0;
          pc      <= taken ? PC_W'(irField[3:0]) : pc + PC_W'(1);
          instret <= instret + 8'd1;
          if (run) begin
            state    <= FETCH;
            imem_req <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: instruction-level reference model with per-cycle compare, directed scenarios and random run.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data;
  logic [3:0] imem_addr;
  logic       imem_req;
  logic [1:0] alu_opcode;
  logic [3:0] alu_addrs;
  logic       alu_carry = 1'b0, alu_borrow = 1'b0, alu_bcf = 1'b0;
  logic       alu_bbf = 1'b0, alu_buc = 1'b0, alu_toggle = 1'b0;
  logic       acc_we, out_bit, busy;
  logic [3:0] pc;
  logic [7:0] instret;

  alu_sequencer #(.PC_W(4)) dut (
    .clk(clk), .rst(rst), .run(run),
`ifdef ALU_SEQ_STEP_EN
    .step(step),
`endif
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_opcode(alu_opcode), .alu_addrs(alu_addrs),
    .alu_carry(alu_carry), .alu_borrow(alu_borrow),
    .alu_bcf(alu_bcf), .alu_bbf(alu_bbf), .alu_buc(alu_buc), .alu_toggle(alu_toggle),
    .acc_we(acc_we), .out_bit(out_bit), .pc(pc), .instret(instret), .busy(busy)
  );

  always #5 clk = ~clk;

  // Program memory and a table-driven stand-in ALU: {carry,borrow,bcf,bbf,buc,toggle}.
  logic [7:0] mem [16];
  logic [5:0] aluTab [64];
  logic       randAlu = 1'b0;
  logic       randDelay = 1'b0;
  int         ackDelay = 0;
  int         reqAge = 0;
  int         curDelay = 0;

  assign imem_data = mem[imem_addr];

  int nErr = 0;
  int nChecks = 0;
  int accWeCnt = 0;
  logic armed = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (randAlu) begin
      alu_carry  = 1'($urandom & 1);
      alu_borrow = 1'($urandom & 1);
      alu_toggle = 1'($urandom & 1);
      alu_bcf    = ($urandom % 4 == 0);
      alu_bbf    = ($urandom % 4 == 0);
      alu_buc    = ($urandom % 6 == 0);
    end else begin
      {alu_carry, alu_borrow, alu_bcf, alu_bbf, alu_buc, alu_toggle} = aluTab[{alu_opcode, alu_addrs}];
    end
    if (imem_req) begin
      if (reqAge == 0) curDelay = randDelay ? int'($urandom % 4) : ackDelay;
      imem_ack = (reqAge == curDelay);
      reqAge++;
    end else begin
      reqAge   = 0;
      imem_ack = randDelay ? ($urandom % 3 == 0) : 1'b0;
    end
  end

  // Reference model: tracks the instruction in flight by its age since the fetch handshake.
  logic [3:0] mPc = 0;
  logic [7:0] mInstret = 0, mIr = 0;
  logic       mCarry = 0, mBorrow = 0, mOut = 0, mReq = 0, mBusy = 0, mIsBr = 0, mTaken = 0;
  int         age = -1;

  always @(negedge clk) begin
    if (armed) begin
      check("pc", 32'(pc), 32'(mPc));
      check("imem_addr", 32'(imem_addr), 32'(mPc));
      check("instret", 32'(instret), 32'(mInstret));
      check("out_bit", 32'(out_bit), 32'(mOut));
      check("busy", 32'(busy), 32'(mBusy));
      check("imem_req", 32'(imem_req), 32'(mReq));
      check("acc_we", 32'(acc_we), 32'(age == 1 && !mIsBr));
      check("alu_opcode", 32'(alu_opcode), 32'(mIr[7:6]));
      check("alu_addrs", 32'(alu_addrs), 32'(mIr[5:2]));
      if (acc_we === 1'b1) accWeCnt++;
    end
    if (rst) begin
      mPc = 0; mInstret = 0; mIr = 0; mCarry = 0; mBorrow = 0; mOut = 0;
      mReq = 0; mBusy = 0; mIsBr = 0; mTaken = 0; age = -1;
    end else if (age == 0) begin
      mIsBr  = alu_buc | alu_bcf | alu_bbf;
      mTaken = alu_buc | (alu_bcf & mCarry) | (alu_bbf & mBorrow);
      if (!mIsBr) begin
        mCarry  = alu_carry;
        mBorrow = alu_borrow;
      end
      if (alu_toggle) mOut = !mOut;
      age = 1;
    end else if (age == 1) begin
      mPc = mTaken ? mIr[5:2] : mPc + 4'd1;
      mInstret = mInstret + 8'd1;
      age = -1;
      mReq = run;
      mBusy = run;
    end else if (mReq) begin
      if (imem_ack) begin
        mIr = mem[mPc];
        mReq = 0;
        age = 0;
      end
    end else if (run || step) begin
      mReq = 1;
      mBusy = 1;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic clearTables();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    for (int i = 0; i < 64; i++) aluTab[i] = 6'h00;
  endtask

  task automatic waitInstret(input logic [7:0] target, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (instret !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_instret", 32'(instret), 32'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt, n, base;
    clearTables();
    run = 1'b0;
    doReset();
    armed = 1'b1;

    // Reset and idle
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_req", 32'(imem_req), 32'd0);
      check("idle_pc", 32'(pc), 32'd0);
      check("idle_opcode", 32'(alu_opcode), 32'd0);
      @(posedge clk); #1;
    end

    // Straight-line execution: acc_we in cycles 3 and 6 after run
    mem[0] = 8'h40; mem[1] = 8'h84;
    run = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("line_acc_we", 32'(acc_we), 32'(k == 3 || k == 6));
      if (k == 2) check("line_op1", 32'({alu_opcode, alu_addrs}), 32'h10);
      if (k == 5) check("line_op2", 32'({alu_opcode, alu_addrs}), 32'h21);
      @(posedge clk); #1;
      if (k == 5) run = 1'b0;
    end
    @(negedge clk);
    check("line_pc", 32'(pc), 32'd2);
    check("line_instret", 32'(instret), 32'd2);
    check("line_busy", 32'(busy), 32'd0);

    // Branch on carry, carry set by the previous instruction: taken to 9
    @(posedge clk); #1;
    clearTables();
    doReset();
    mem[0] = 8'h40; aluTab[6'h10] = 6'b100000;
    mem[1] = 8'h24; aluTab[6'h09] = 6'b001000;
    base = accWeCnt;
    run = 1'b1;
    waitInstret(8'd2, 30);
    check("bcf_taken_pc", 32'(pc), 32'd9);
    check("bcf_taken_acc", 32'(accWeCnt - base), 32'd1);
    @(posedge clk); #1;
    run = 1'b0;
    waitInstret(8'd3, 30);

    // Same branch with carry cleared: falls through
    @(posedge clk); #1;
    doReset();
    mem[0] = 8'h80;
    base = accWeCnt;
    run = 1'b1;
    waitInstret(8'd2, 30);
    check("bcf_nt_pc", 32'(pc), 32'd2);
    check("bcf_nt_acc", 32'(accWeCnt - base), 32'd1);
    @(posedge clk); #1;
    run = 1'b0;
    waitInstret(8'd3, 30);

    // Memory wait and PC wrap
    @(posedge clk); #1;
    clearTables();
    doReset();
    mem[0] = 8'h3C; aluTab[6'h0F] = 6'b000010;
    ackDelay = 3;
    run = 1'b1;
    waitInstret(8'd1, 40);
    check("wrap_pc15", 32'(pc), 32'd15);
    cnt = 0; n = 0;
    while (imem_req === 1'b1 && n < 20) begin
      cnt++;
      check("wrap_addr", 32'(imem_addr), 32'd15);
      @(negedge clk);
      n++;
    end
    check("wrap_req_cycles", 32'(cnt), 32'd4);
    @(posedge clk); #1;
    run = 1'b0;
    waitInstret(8'd2, 20);
    check("wrap_pc0", 32'(pc), 32'd0);
    ackDelay = 0;

    // Reset asserted in EXEC
    @(posedge clk); #1;
    clearTables();
    doReset();
    mem[0] = 8'h40; aluTab[6'h10] = 6'b100001;
    run = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(imem_req === 1'b1 && imem_ack === 1'b1) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("exec_hs_seen", 32'(imem_req & imem_ack), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; run = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstx_busy", 32'(busy), 32'd0);
    check("rstx_out", 32'(out_bit), 32'd0);
    check("rstx_acc", 32'(acc_we), 32'd0);
    check("rstx_req", 32'(imem_req), 32'd0);
    @(posedge clk); #1;
    mem[0] = 8'h24; aluTab[6'h09] = 6'b001000;
    run = 1'b1;
    waitInstret(8'd1, 20);
    check("rstx_carry_clr", 32'(pc), 32'd1);
    @(posedge clk); #1;
    run = 1'b0;
    waitInstret(8'd2, 20);

    // run dropped during FETCH: instruction still completes
    @(posedge clk); #1;
    clearTables();
    doReset();
    mem[0] = 8'h40;
    ackDelay = 2;
    run = 1'b1;
    cyc(2);
    run = 1'b0;
    waitInstret(8'd1, 20);
    repeat (3) @(negedge clk);
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_instret", 32'(instret), 32'd1);
    ackDelay = 0;

`ifdef ALU_SEQ_STEP_EN
    // Single step
    @(posedge clk); #1;
    clearTables();
    doReset();
    mem[0] = 8'h40; mem[1] = 8'h84;
    base = accWeCnt;
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(6);
    @(negedge clk);
    check("step1_instret", 32'(instret), 32'd1);
    check("step1_busy", 32'(busy), 32'd0);
    check("step1_acc", 32'(accWeCnt - base), 32'd1);
    @(posedge clk); #1;
    step = 1'b1;
    cyc(1);
    step = 1'b0;
    cyc(6);
    @(negedge clk);
    check("step2_instret", 32'(instret), 32'd2);
    check("step2_pc", 32'(pc), 32'd2);
`endif

    // Randomized run against the model
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    randAlu = 1'b1;
    randDelay = 1'b1;
    doReset();
    run = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      cyc(1);
      rst = ($urandom % 150 == 0);
      if ($urandom % 20 == 0) run = !run;
`ifdef ALU_SEQ_STEP_EN
      step = (!run && $urandom % 8 == 0);
`endif
      if ($urandom % 10 == 0) mem[$urandom % 16] = 8'($urandom);
    end
    rst = 1'b0; run = 1'b0; step = 1'b0;
    cyc(20);

    $display("Result: errors=%0d of %0d checks", nErr, nChecks);
    $finish;
  end

endmodule
